// File: rtl/bn_pkg.sv
// Shared types, constants and the fixed-point round/shift/saturate helper for the BN pipe.
package bn_pkg;

  localparam int unsigned BN_DATA_W    = 16;
  localparam int unsigned BN_FRAC_BITS = 8;
  localparam int unsigned BN_PROD_W    = 2 * BN_DATA_W;
  localparam int unsigned BN_SUM_W     = 2 * BN_DATA_W + 1;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_RELU6 = 2'd2
  } act_mode_e;

  typedef struct packed {
    logic signed [BN_DATA_W-1:0] y;
    logic                        sat;
  } bn_res_t;

  localparam logic signed [BN_SUM_W-1:0] BN_SUM_MAX = BN_SUM_W'((2 ** (BN_DATA_W - 1)) - 1);
  localparam logic signed [BN_SUM_W-1:0] BN_SUM_MIN = -BN_SUM_W'(2 ** (BN_DATA_W - 1));
  localparam logic signed [BN_SUM_W-1:0] BN_RND     = BN_SUM_W'(1 << (BN_FRAC_BITS - 1));

  // Round-half-up the Q product back to sample scale, add shift, clamp to sample range.
  function automatic bn_res_t sat_round(input logic signed [BN_PROD_W-1:0] p,
                                        input logic signed [BN_DATA_W-1:0] shift);
    logic signed [BN_SUM_W-1:0] r;
    logic signed [BN_SUM_W-1:0] s;
    bn_res_t                    res;
    res = '0;
    r   = (BN_SUM_W'(p) + BN_RND) >>> BN_FRAC_BITS;
    s   = r + BN_SUM_W'(shift);
    if (s > BN_SUM_MAX) begin
      res.y   = {1'b0, {(BN_DATA_W - 1){1'b1}}};
      res.sat = 1'b1;
    end else if (s < BN_SUM_MIN) begin
      res.y   = {1'b1, {(BN_DATA_W - 1){1'b0}}};
      res.sat = 1'b1;
    end else begin
      res.y   = BN_DATA_W'(s);
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/bn_param_rf.sv
// Per-channel scale/shift register file: identity on reset, one write port, one registered read port.
module bn_param_rf
  import bn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = BN_DATA_W,
  parameter int unsigned FRAC_BITS    = BN_FRAC_BITS,
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [CH_W-1:0]              i_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] i_wr_scale,
  input  logic signed [DATA_WIDTH-1:0] i_wr_shift,
  input  logic                         i_rd_en,
  input  logic [CH_W-1:0]              i_rd_addr,
  output logic signed [DATA_WIDTH-1:0] o_rd_scale,
  output logic signed [DATA_WIDTH-1:0] o_rd_shift
);

  localparam logic signed [DATA_WIDTH-1:0] SCALE_ONE = DATA_WIDTH'(1 << FRAC_BITS);

  logic signed [DATA_WIDTH-1:0] r_scale [NUM_CHANNELS];
  logic signed [DATA_WIDTH-1:0] r_shift [NUM_CHANNELS];

  // Parameter storage; reset restores pass-through (scale 1.0, shift 0) on every channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_scale[i] <= SCALE_ONE;
        r_shift[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_scale[i_wr_addr] <= i_wr_scale;
      r_shift[i_wr_addr] <= i_wr_shift;
    end
  end

  // Registered read; a write on the same edge is not yet visible, so the reader sees the old entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_rd_scale <= SCALE_ONE;
      o_rd_shift <= '0;
    end else if (i_rd_en) begin
      o_rd_scale <= r_scale[i_rd_addr];
      o_rd_shift <= r_shift[i_rd_addr];
    end
  end

endmodule

// File: rtl/bn_channel_pipe.sv
// Channel-interleaved folded batch-norm with optional ReLU/ReLU6, valid/ready streaming.
// Stages: S1 lookup (sample + param read), S2 multiply, S3 round/shift/saturate, then the
// output register applies the activation.
module bn_channel_pipe
  import bn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = BN_DATA_W,
  parameter int unsigned FRAC_BITS    = BN_FRAC_BITS,
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic signed [DATA_WIDTH-1:0] cfg_scale,
  input  logic signed [DATA_WIDTH-1:0] cfg_shift,
  input  logic [1:0]                   act_mode,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         sat_flag
);

  localparam int unsigned              PROD_W    = 2 * DATA_WIDTH;
  localparam logic [CH_W-1:0]          CH_LAST   = CH_W'(NUM_CHANNELS - 1);
  localparam logic signed [DATA_WIDTH-1:0] RELU6_MAX = DATA_WIDTH'(6 << FRAC_BITS);

  logic                         w_stall;
  logic                         w_accept;
  logic [CH_W-1:0]              w_in_ch_nxt;
  logic signed [DATA_WIDTH-1:0] w_rf_scale;
  logic signed [DATA_WIDTH-1:0] w_rf_shift;
  logic signed [PROD_W-1:0]     w_prod;
  bn_res_t                      w_sr;
  logic signed [DATA_WIDTH-1:0] w_act_y;

  logic                         r_rdy_en;
  logic [CH_W-1:0]              r_in_ch;
  logic                         r_s1_valid;
  logic signed [DATA_WIDTH-1:0] r_s1_data;
  logic [CH_W-1:0]              r_s1_ch;
  logic                         r_s2_valid;
  logic signed [PROD_W-1:0]     r_s2_prod;
  logic signed [DATA_WIDTH-1:0] r_s2_shift;
  logic [CH_W-1:0]              r_s2_ch;
  logic                         r_s3_valid;
  bn_res_t                      r_s3_res;
  logic [CH_W-1:0]              r_s3_ch;

  assign w_stall  = out_valid && !out_ready;
  assign in_ready = r_rdy_en && !w_stall;
  assign w_accept = in_valid && in_ready;

  bn_param_rf #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRAC_BITS   (FRAC_BITS),
    .NUM_CHANNELS(NUM_CHANNELS),
    .CH_W        (CH_W)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (cfg_we),
    .i_wr_addr (cfg_ch),
    .i_wr_scale(cfg_scale),
    .i_wr_shift(cfg_shift),
    .i_rd_en   (w_accept),
    .i_rd_addr (r_in_ch),
    .o_rd_scale(w_rf_scale),
    .o_rd_shift(w_rf_shift)
  );

  // Next input channel, wrapping after the last channel
  always_comb begin
    w_in_ch_nxt = r_in_ch + CH_W'(1);
    if (r_in_ch == CH_LAST) begin
      w_in_ch_nxt = '0;
    end
  end

  // Input channel counter (advances only on accept) and post-reset ready enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_en <= 1'b0;
      r_in_ch  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_in_ch <= w_in_ch_nxt;
      end
    end
  end

  // S1: capture sample and its channel; the RF read lands alongside it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_ch    <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= in_data;
        r_s1_ch   <= r_in_ch;
      end
    end
  end

  assign w_prod = PROD_W'(r_s1_data) * PROD_W'(w_rf_scale);

  // S2: full-precision product
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_shift <= '0;
      r_s2_ch    <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_prod  <= w_prod;
      r_s2_shift <= w_rf_shift;
      r_s2_ch    <= r_s1_ch;
    end
  end

  assign w_sr = sat_round(r_s2_prod, r_s2_shift);

  // S3: rounded, shifted and saturated result with its clamp indication
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s3_valid <= 1'b0;
      r_s3_res   <= '0;
      r_s3_ch    <= '0;
    end else if (!w_stall) begin
      r_s3_valid <= r_s2_valid;
      r_s3_res   <= w_sr;
      r_s3_ch    <= r_s2_ch;
    end
  end

  // Activation on the saturated value; its clamping is not a saturation event
  always_comb begin
    w_act_y = r_s3_res.y;
    case (act_mode_e'(act_mode))
      ACT_RELU: begin
        if (r_s3_res.y < 0) w_act_y = '0;
      end
      ACT_RELU6: begin
        if (r_s3_res.y < 0) begin
          w_act_y = '0;
        end else if (r_s3_res.y > RELU6_MAX) begin
          w_act_y = RELU6_MAX;
        end
      end
      default: w_act_y = r_s3_res.y;
    endcase
  end

  // Output register and sticky saturation flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (!w_stall) begin
      out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        out_data <= w_act_y;
        out_ch   <= r_s3_ch;
        out_last <= (r_s3_ch == CH_LAST);
        if (r_s3_res.sat) begin
          sat_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/bn_channel_pipe.md
Name: bn_channel_pipe

Overview:
Multi-channel, pipelined successor to the single-value BatchNorm_param block, used in the SE layer and conv output paths. Applies per-channel folded batch-norm, y = sat(round(x*scale) + shift), and then an optional activation (none, ReLU, ReLU6). Channels arrive interleaved, one sample per channel in order 0..NUM_CHANNELS-1, then repeat. Per-channel scale/shift live in an internal register file loaded over a config port. Streaming uses valid/ready with full backpressure.

Parameters:
DATA_WIDTH, 16, signed sample and shift width (Q format with FRAC_BITS fraction bits)
FRAC_BITS, 8, fraction bits of scale; also the ReLU6 scaling (6.0 = 6<<FRAC_BITS)
NUM_CHANNELS, 16, channel count, ≥2
CH_W, $clog2(NUM_CHANNELS), channel index width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
cfg_we  in  1  write scale/shift for cfg_ch
cfg_ch  in  CH_W  config channel index
cfg_scale  in  DATA_WIDTH  signed scale = gamma/sqrt(var+eps), Q(FRAC_BITS)
cfg_shift  in  DATA_WIDTH  signed shift = beta - mean*scale
act_mode  in  2  0 none, 1 ReLU, 2 ReLU6, 3 reserved (treated as none); quasi-static
in_data  in  DATA_WIDTH  signed sample
in_valid  in  1  sample valid
in_ready  out  1  block accepts a sample
out_data  out  DATA_WIDTH  signed result
out_ch  out  CH_W  channel of out_data
out_last  out  1  out_ch == NUM_CHANNELS-1
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
sat_flag  out  1  sticky; set when any result saturates

Behaviour:
- Reset (rst low, async): out_data=0, out_ch=0, out_last=0, out_valid=0, sat_flag=0. Input channel counter is set to 0 and the pipeline valid bits are cleared. Every channel's scale is set to 1<<FRAC_BITS and shift to 0, so the block is pass-through after reset. in_ready=1 one cycle after reset release.
- Pipeline has 3 stages (S1 lookup, S2 multiply, S3 round/add/saturate/activate).
  - Latency: an input accepted at edge N gives out_valid at edge N+3 when there is no stall.
- Accept condition: in_valid && in_ready.
  - On accept, S1 captures in_data and the current channel counter.
  - The counter increments and wraps NUM_CHANNELS-1 -> 0.
  - The counter advances only on accept.
- Stall: stall = out_valid && !out_ready. During stall every stage holds its contents and in_ready = 0; otherwise in_ready = 1. Bubbles propagate normally.
- Register file read happens in S1 with a registered read.
  - A cfg_we to the same channel in the same cycle: the sample uses the OLD value, and the new value applies to later samples.
  - cfg writes are accepted in any cycle, including during stall.
- Arithmetic:
  - p = in_data*scale, 2*DATA_WIDTH signed.
  - r = (p + (1<<(FRAC_BITS-1))) >>> FRAC_BITS, arithmetic shift, round half up.
  - s = r + sign-extended shift, computed in 2*DATA_WIDTH+1 bits.
  - Saturate s to [-2^(DW-1), 2^(DW-1)-1]; any clamp sets sat_flag.
- Activation after saturation:
  - ReLU: y = max(y, 0).
  - ReLU6: y = min(max(y, 0), 6<<FRAC_BITS).
  - Activation clamping does NOT set sat_flag.
- sat_flag clears only on reset.
- Reset mid-stream: all in-flight samples are dropped with no output. The config register file is reset to identity.

Decomposition:
- Package bn_pkg:
  - act_mode_e enum (ACT_NONE, ACT_RELU, ACT_RELU6).
  - Default DATA_WIDTH/FRAC_BITS constants.
  - A function sat_round(p, shift), used by RTL and by the bench reference model.
- One sub-module, bn_param_rf: NUM_CHANNELS-entry scale/shift register file with identity reset, one write port and one registered read port.

Test Plan:
- Reset then identity: stream ch0..3 = 100, -7, 0, 32767 with out_ready=1 -> same values, in_valid high at edge N gives output at N+3; out_ch 0..3; sat_flag=0.
- Config ch1: scale=256, shift=-5; send ch0=15 then ch1=15 -> ch0 15, ch1 10. Also ch2 with scale=128 and input 3 -> 2 (1.5 rounds up).
- Saturation: ch0 scale=512, in=30000 -> 32767 and sat_flag=1. Next in=-30000 -> -32768. sat_flag stays 1 through later normal samples.
- Activation: act_mode=2, identity scale, in=2000 -> 1536; in=-50 -> 0. act_mode=1, in=2000 -> 2000.
- Backpressure: stream 2*NUM_CHANNELS samples with out_ready toggled randomly plus a 5-cycle hold low. Expect no loss or duplication, out_data/out_ch held stable while stalled, in_ready low during stall, and out_last exactly at each ch NUM_CHANNELS-1.
- Reset mid-stream: pull rst low with 2 samples in flight -> out_valid=0 immediately. After release, the first accepted sample is channel 0 with identity parameters.
